// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
//
// One iteration per clock, 32 iterations per operation. Multiply is a
// shift-add on operand magnitudes; divide is restoring division on
// magnitudes. Signs are applied in FIX together with the output select.
//
// Handshake: start is a level held by EX until done. done is a one-cycle
// pulse with result valid in the same cycle. stall = start & ~done & ~flush
// holds the instruction in EX. flush aborts any operation without a done.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   start      EX holds a valid M-extension instruction (level)
//   funct3     0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   operand_a  rs1 after forwarding
//   operand_b  rs2 after forwarding
//   flush      squash EX, abort current operation
//   stall      combinational stall request to the pipeline
//   done       one-cycle completion pulse (registered)
//   result     registered result, held until the next done
module muldiv_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    // state is kept as a plain internal signal so checkers can bind to it.
    state_t      state;
    logic [2:0]  op;
    logic [31:0] opnd;      // multiplicand (mul) or divisor (div) magnitude
    logic [63:0] acc;       // mul: {hi, multiplier/lo}; div: {rem, dividend/quotient}
    logic        neg_res;   // negate product / quotient
    logic        neg_rem;   // remainder takes sign of dividend
    logic [5:0]  cnt;

    logic        a_signed;
    logic        b_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        div_ovf;
    logic [32:0] sum;
    logic [63:0] shifted;
    logic [32:0] trial;
    logic [63:0] acc_next;
    logic [63:0] prod;
    logic [31:0] fix_val;

    assign stall = start & ~done & ~flush;

    // Operand decode, evaluated on the live inputs; only consumed in IDLE.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'd2: a_signed = 1'b1;
            default: ;
        endcase
        a_neg    = a_signed & operand_a[31];
        b_neg    = b_signed & operand_b[31];
        a_mag    = a_neg ? (32'd0 - operand_a) : operand_a;
        b_mag    = b_neg ? (32'd0 - operand_b) : operand_b;
        div_zero = funct3[2] && (operand_b == 32'd0);
        div_ovf  = (funct3 == 3'd4 || funct3 == 3'd6) &&
                   (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
    end

    // One iteration of the datapath.
    always_comb begin
        sum     = {1'b0, acc[63:32]} + {1'b0, opnd};
        shifted = {acc[62:0], 1'b0};
        trial   = {1'b0, shifted[63:32]} - {1'b0, opnd};
        if (op[2]) begin
            // Borrow in trial[32] means the divisor did not fit: restore.
            acc_next = trial[32] ? shifted : {trial[31:0], shifted[31:1], 1'b1};
        end else begin
            // The carry out of the add becomes the new MSB after the shift.
            acc_next = acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]};
        end
    end

    // Sign fix and output select, applied to the final iteration's value so
    // result and done can both be registered on the edge entering FIX.
    always_comb begin
        prod = neg_res ? (64'd0 - acc_next) : acc_next;
        case (op)
            3'd0:                fix_val = prod[31:0];
            3'd1, 3'd2, 3'd3:    fix_val = prod[63:32];
            3'd4, 3'd5:          fix_val = neg_res ? (32'd0 - acc_next[31:0]) : acc_next[31:0];
            default:             fix_val = neg_rem ? (32'd0 - acc_next[63:32]) : acc_next[63:32];
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            op      <= 3'd0;
            opnd    <= 32'd0;
            acc     <= 64'd0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            cnt     <= 6'd0;
            done    <= 1'b0;
            result  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    cnt  <= 6'd0;
                    if (start && !flush) begin
                        op      <= funct3;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        if (div_zero) begin
                            result <= funct3[1] ? operand_a : 32'hFFFF_FFFF;
                            done   <= 1'b1;
                            state  <= FIX;
                        end else if (div_ovf) begin
                            result <= funct3[1] ? 32'd0 : 32'h8000_0000;
                            done   <= 1'b1;
                            state  <= FIX;
                        end else begin
                            if (funct3[2]) begin
                                acc  <= {32'd0, a_mag};
                                opnd <= b_mag;
                            end else begin
                                acc  <= {32'd0, b_mag};
                                opnd <= a_mag;
                            end
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            result <= fix_val;
                            done   <= 1'b1;
                            state  <= FIX;
                        end
                    end
                end
                FIX: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge. Expected values are hand-computed constants.
module tb_muldiv_unit;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    int cyc;
    int stall_hi;
    logic [31:0] prior;

    muldiv_unit dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .stall     (stall),
        .done      (done),
        .result    (result)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver: start an op at the beginning of the next cycle (cycle k).
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(posedge CLK);
        #1;
        start     = 1'b1;
        funct3    = f;
        operand_a = a;
        operand_b = b;
    endtask

    // Wait for done, counting cycles before the done cycle and the number
    // of those cycles with stall high. Leaves time at the done-cycle negedge.
    task automatic wait_done(input string tag);
        cyc      = 0;
        stall_hi = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (done) break;
            if (stall) stall_hi++;
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed=no done expected=done within 100 cycles", tag);
        end
    endtask

    task automatic end_op();
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    // Full directed op: latency counted in cycles from k to the done cycle.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        start_op(f, a, b);
        wait_done(tag);
        check({tag, "_result"}, result, exp);
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_stall_cycles"}, stall_hi, lat);
        check({tag, "_stall_at_done"}, {31'd0, stall}, 32'd0);
        end_op();
    endtask

    initial begin
        RST       = 1'b1;
        start     = 1'b0;
        funct3    = 3'd0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        flush     = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_result", result, 32'h0000_0000);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Multiply family
        run_op("mul_7x-3",    3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh",        3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("mulhsu",      3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run_op("mulhu",       3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 33);

        // Divide family
        run_op("div_-7_2",    3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        run_op("rem_-7_2",    3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_op("divu_100_7",  3'd5, 32'd100,       32'd7,         32'd14,        33);
        run_op("remu_100_7",  3'd7, 32'd100,       32'd7,         32'd2,         33);

        // Special cases finish in cycle k+1
        run_op("div_by0",     3'd4, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        run_op("rem_by0",     3'd6, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1);
        run_op("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Flush mid-CALC: no done, result held, unit idle the next cycle.
        run_op("mul_pre",     3'd0, 32'd9,         32'd11,        32'd99,        33);
        prior = 32'd99;
        start_op(3'd0, 32'd3, 32'd4);
        repeat (10) begin
            @(negedge CLK);
            check("flush_no_done_calc", {31'd0, done}, 32'd0);
            @(posedge CLK);
        end
        #1;
        flush     = 1'b1;
        operand_a = 32'd13;
        operand_b = 32'd17;
        #1 check("flush_stall_low", {31'd0, stall}, 32'd0);
        @(negedge CLK);
        check("flush_no_done", {31'd0, done}, 32'd0);
        check("flush_result_held", result, prior);
        @(posedge CLK);
        #1 flush = 1'b0;
        // start still high: the new op must begin right away from IDLE
        wait_done("after_flush");
        check("after_flush_latency", cyc, 33);
        check("after_flush_result", result, 32'd221);
        end_op();

        // Async reset mid-CALC clears result and done at once.
        start_op(3'd5, 32'd1000, 32'd3);
        repeat (5) @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        check("async_rst_result", result, 32'h0000_0000);
        check("async_rst_done", {31'd0, done}, 32'd0);
        @(posedge CLK);
        #1;
        RST   = 1'b0;
        start = 1'b0;
        run_op("post_rst_divu", 3'd5, 32'd1000, 32'd3, 32'd333, 33);

        // Back-to-back MULs with start held; operands change in the done cycle.
        start_op(3'd0, 32'd5, 32'd6);
        wait_done("b2b_first");
        check("b2b_first_result", result, 32'd30);
        operand_a = 32'h0000_0010;
        operand_b = 32'hFFFF_FFE0;
        // From the first done, the second done is 34 cycles later: 33 cycles
        // counted before it by wait_done.
        wait_done("b2b_second");
        check("b2b_second_gap", cyc + 1, 34);
        check("b2b_second_result", result, 32'hFFFF_FE00);
        end_op();

        repeat (3) @(negedge CLK);
        check("idle_no_done", {31'd0, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. Consumes the post-forwarding operands that feed the ALU and produces a 32-bit result for the EX/MEM latch. While an operation is in flight it raises a stall request, so the instruction is held in EX until the result is ready. Fully sequential: one iteration per clock, 32 iterations per operation.

## Interface
- No parameters; datapath fixed at 32 bits.
- CLK  input  1  clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  EX holds a valid M-extension instruction; level, held until `done`.
- funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- operand_a  input  32  rs1 value after forwarding mux.
- operand_b  input  32  rs2 value after forwarding mux.
- flush  input  1  squash EX (branch mispredict/exception); aborts the operation.
- stall  output  1  combinational: `start & ~done & ~flush`.
- done  output  1  one-cycle pulse; `result` is valid in the same cycle.
- result  output  32  registered result; holds its value until the next `done`.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - If `start & ~flush`, latch `funct3` and the operand magnitudes plus sign flags. Signedness: MUL/MULH/DIV/REM use a and b signed; MULHSU uses a signed, b unsigned; others unsigned.
  - Clear the 6-bit iteration counter.
  - Go to CALC, or go to FIX directly on a special case.
- Special cases, detected in IDLE:
  - Divide by zero (b==0, funct3 4-7): quotient 0xFFFFFFFF; remainder = operand_a unchanged.
  - Signed overflow (DIV/REM, a==0x80000000, b==0xFFFFFFFF): quotient 0x80000000; remainder 0.
- CALC, multiply: shift-add on magnitudes. Each cycle, if the multiplier LSB is 1, add the multiplicand to the upper accumulator half. Shift the 65-bit {carry, acc} right by 1.
- CALC, divide: restoring division on magnitudes. Each cycle, shift {rem, dividend} left by 1; trial-subtract the divisor; on no borrow, keep the difference and set the quotient bit.
- CALC exits after exactly 32 iterations (counter reaches 31) and goes to FIX.
- FIX:
  - Apply the sign. Product is negated as 64-bit when the sign flags differ. Quotient is negated when the signs differ. Remainder takes the sign of the dividend.
  - Select the output: MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Register `result`, assert `done`, return to IDLE.
- flush in any state: next state IDLE, no `done`, `result` unchanged. A flush in IDLE suppresses the start.
- Back-to-back: if `start` is still high in the cycle after `done` (a new instruction in EX), the next operation starts from IDLE normally. `funct3` and operands are resampled then.
- Operands and `funct3` are sampled only in IDLE. Changes during CALC are ignored.
- Reset (async, any state): state IDLE, counter 0, `result` 0x00000000, `done` 0, internal registers 0. `stall` then follows its combinational equation.

## Timing
- With `start` first high in cycle k (state IDLE):
  - Normal op: CALC in cycles k+1..k+32, FIX in k+33. `done`=1 and `result` are valid in cycle k+33.
  - Special case: FIX in k+1, `done` in cycle k+1.
- `stall` is high in cycles k..k+32 and low in k+33. The pipeline advances on the `done` edge.
- `done` is high for exactly one cycle per accepted operation and is never asserted in IDLE or CALC.
- No combinational path from operands to `result`. The only combinational output path is `start`/`flush` to `stall`.

## Test plan
- MUL 7 × -3 (a=0x00000007, b=0xFFFFFFFD) -> `done` in cycle k+33; result 0xFFFFFFEB; `stall` high for exactly 33 cycles.
- MULH/MULHSU/MULHU with a=0x80000000, b=0xFFFFFFFF -> 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV x/0 -> 0xFFFFFFFF and REM x/0 -> x, both with `done` at k+1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, also at k+1.
- `flush` at iteration 10 -> IDLE next cycle, no `done`, `result` keeps its prior value. Async `RST` mid-CALC -> `result` 0, `done` 0 immediately.
- Two back-to-back MULs (start held, operands changed on the `done` cycle) -> second `done` exactly 34 cycles after the first, with the correct second product.
